// File: rtl/edge_memory_node_pkg.sv
// Shared defaults and helpers for the stochastic-decoder equality node with edge memory.
package edge_memory_node_pkg;

  localparam int EM_S_DEFAULT  = 8;
  localparam int SEL_W_DEFAULT = 3;

  // Number of addressable slots for a select bus of the given width.
  function automatic int sel_span(input int ns);
    return 1 << ns;
  endfunction

endpackage

// File: rtl/edge_memory_node_sel_mux.sv
// Generic binary-select mux: out = in_bits[sel], or 0 when sel addresses past NR inputs.
module edge_memory_node_sel_mux
  import edge_memory_node_pkg::*;
#(
  parameter int NR = 2,
  parameter int NS = 1
) (
  input  logic [NR-1:0] in_bits,
  input  logic [NS-1:0] sel,
  output logic          out
);

  localparam int SPAN = sel_span(NS);

  // Pad the input vector out to the full select range so unused codes read 0
  // without a range comparison.
  logic [SPAN-1:0] padded;

  genvar gi;
  generate
    for (gi = 0; gi < SPAN; gi++) begin : g_pad
      if (gi < NR) begin : g_live
        assign padded[gi] = in_bits[gi];
      end else begin : g_zero
        assign padded[gi] = 1'b0;
      end
    end
  endgenerate

  assign out = padded[sel];

endmodule

// File: rtl/edge_memory_node.sv
// Degree-3 equality node with an edge memory of recent regenerative bits; hold states
// replay a randomly addressed EM bit.
module edge_memory_node
  import edge_memory_node_pkg::*;
#(
  parameter int EM_S  = EM_S_DEFAULT,
  parameter int SEL_W = SEL_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             INIT,
  input  logic             c,
  input  logic [1:0]       R,
  input  logic [SEL_W-1:0] EM_SEL,
  output logic             Q,
  output logic             EM_FLAG
);

  logic [EM_S-1:0] mem_reg;
  logic            temp_a;
  logic            temp_b;
  logic            u;
  logic            upd;
  logic            em_in;
  logic            em_out;
  logic            q_next;

  assign temp_a = R[0] & R[1] & c;
  assign temp_b = ~R[0] & ~R[1] & ~c;
  assign u      = temp_a | temp_b;
  assign upd    = INIT | u;

  edge_memory_node_sel_mux #(.NR(2), .NS(1)) u_in_mux (
    .in_bits ({c, temp_a}),
    .sel     (INIT),
    .out     (em_in)
  );

  // Read uses the pre-edge contents, so a same-cycle write never bypasses here.
  edge_memory_node_sel_mux #(.NR(EM_S), .NS(SEL_W)) u_read_mux (
    .in_bits (mem_reg),
    .sel     (EM_SEL),
    .out     (em_out)
  );

  edge_memory_node_sel_mux #(.NR(2), .NS(1)) u_out_mux (
    .in_bits ({em_in, em_out}),
    .sel     (upd),
    .out     (q_next)
  );

  // mem_reg[0] is the newest entry; the oldest falls off the top on each update.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mem_reg <= '0;
      Q       <= 1'b0;
      EM_FLAG <= 1'b0;
    end else begin
      Q <= q_next;
      if (upd) begin
        mem_reg <= {mem_reg[EM_S-2:0], em_in};
        EM_FLAG <= ~EM_FLAG;
      end
    end
  end

endmodule

// File: tb/tb_edge_memory_node.sv
// Directed self-checking bench for edge_memory_node with hand-computed expectations.
module tb_edge_memory_node;

  logic       clk;
  logic       rst;
  logic       init;
  logic       c;
  logic [1:0] r;
  logic [2:0] em_sel;
  logic       q;
  logic       em_flag;

  int checks;
  int failures;

  edge_memory_node #(.EM_S(8), .SEL_W(3)) dut (
    .CLK     (clk),
    .RST     (rst),
    .INIT    (init),
    .c       (c),
    .R       (r),
    .EM_SEL  (em_sel),
    .Q       (q),
    .EM_FLAG (em_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs on the falling edge, clock once, then sample just after the rising edge.
  task automatic step(input logic s_rst, input logic s_init, input logic s_c,
                      input logic [1:0] s_r, input logic [2:0] s_sel);
    @(negedge clk);
    rst    = s_rst;
    init   = s_init;
    c      = s_c;
    r      = s_r;
    em_sel = s_sel;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  logic [7:0] init_bits;
  logic [7:0] exp_mem;

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1; init = 1'b1; c = 1'b1; r = 2'b11; em_sel = '0;

    // Reset for two cycles while INIT and c are high.
    step(1'b1, 1'b1, 1'b1, 2'b11, 3'd0);
    step(1'b1, 1'b1, 1'b1, 2'b11, 3'd0);
    check("rst_q", q, 1'b0);
    check("rst_flag", em_flag, 1'b0);

    // Hold state (R=01, c=0): every EM address reads zero after reset.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 2'b01, 3'(i));
      check($sformatf("rst_mem%0d", i), q, 1'b0);
    end
    check("rst_hold_flag", em_flag, 1'b0);

    // INIT load of c = 1,0,1,1,0,0,1,0 (bit 7 driven first).
    init_bits = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, init_bits[7-i], 2'b01, 3'd0);
      check($sformatf("init_q%0d", i), q, init_bits[7-i]);
      check($sformatf("init_flag%0d", i), em_flag, ((i + 1) % 2) == 1);
    end

    // EM now holds mem[0]=0 (last loaded) ... mem[7]=1 (first loaded).
    step(1'b0, 1'b0, 1'b0, 2'b01, 3'd0);
    check("load_sel0", q, 1'b0);
    step(1'b0, 1'b0, 1'b0, 2'b01, 3'd1);
    check("load_sel1", q, 1'b1);
    step(1'b0, 1'b0, 1'b0, 2'b01, 3'd7);
    check("load_sel7", q, 1'b1);
    check("load_flag", em_flag, 1'b0);

    // Regenerative 1 then regenerative 0.
    step(1'b0, 1'b0, 1'b1, 2'b11, 3'd5);
    check("regen1_q", q, 1'b1);
    check("regen1_flag", em_flag, 1'b1);
    step(1'b0, 1'b0, 1'b0, 2'b00, 3'd4);
    check("regen0_q", q, 1'b0);
    check("regen0_flag", em_flag, 1'b0);

    // Hold (R=10, c=1) for 16 cycles with sweeping address; EM is frozen.
    exp_mem = 8'b1100_1010;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'b10, 3'(i % 8));
      check($sformatf("hold_q%0d", i), q, exp_mem[i % 8]);
    end
    check("hold_flag", em_flag, 1'b0);

    // INIT dominates tempA: R=00, c=1 still writes a 1.
    step(1'b0, 1'b1, 1'b1, 2'b00, 3'd3);
    check("initpri_q", q, 1'b1);
    check("initpri_flag", em_flag, 1'b1);
    step(1'b0, 1'b0, 1'b1, 2'b10, 3'd0);
    check("initpri_sel0", q, 1'b1);
    step(1'b0, 1'b0, 1'b1, 2'b10, 3'd1);
    check("initpri_sel1", q, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b10, 3'd2);
    check("initpri_sel2", q, 1'b1);

    // RST dominates INIT and a regenerative input.
    step(1'b1, 1'b1, 1'b1, 2'b11, 3'd0);
    check("rstpri_q", q, 1'b0);
    check("rstpri_flag", em_flag, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b10, 3'd0);
    check("rstpri_sel0", q, 1'b0);
    step(1'b0, 1'b0, 1'b1, 2'b10, 3'd2);
    check("rstpri_sel2", q, 1'b0);
    check("rstpri_hold_flag", em_flag, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
